// File: rtl/mem_loader.sv
// mem_loader: streams bytes into a downstream memory at base..base+length-1 with checksum.
// Define MEM_LOADER_VERIFY_EN to add a readback pass that re-sums memory and flags mismatches.
module mem_loader #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] base_addr_i,
  input  logic [7:0] length_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_din_o,
  output logic       mem_we_o,
  input  logic [7:0] mem_dout_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [8:0] count_o,
  output logic [7:0] checksum_o
);
`ifdef MEM_LOADER_VERIFY_EN
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  localparam logic [7:0] LIM = 8'(STALL_LIMIT);
  state_t     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [8:0] len_q, len_d;
  logic [8:0] count_q, count_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] stall_q, stall_d;
  logic       err_q, err_d;
`ifdef MEM_LOADER_VERIFY_EN
  logic [8:0] vidx_q, vidx_d;
  logic [7:0] vsum_q, vsum_d;
`else
  logic       unused_dout;
  assign unused_dout = ^mem_dout_i;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
      vidx_q  <= '0;
      vsum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      stall_q <= stall_d;
      err_q   <= err_d;
`ifdef MEM_LOADER_VERIFY_EN
      vidx_q  <= vidx_d;
      vsum_q  <= vsum_d;
`endif
    end
  end
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    sum_d      = sum_q;
    stall_d    = stall_q;
    err_d      = err_q;
    in_ready_o = state_q == LOAD;
    mem_we_o   = in_ready_o && in_valid_i;
    mem_din_o  = in_ready_o ? in_data_i : 8'h00;
`ifdef MEM_LOADER_VERIFY_EN
    vidx_d     = vidx_q;
    vsum_d     = vsum_q;
    mem_addr_o = base_q + ((state_q == VERIFY) ? vidx_q[7:0] : count_q[7:0]);
`else
    mem_addr_o = base_q + count_q[7:0];
`endif
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = LOAD;
        base_d  = base_addr_i;
        len_d   = {length_i == 8'h00, length_i};  // a length of 0 encodes 256
        count_d = '0;
        sum_d   = '0;
        stall_d = '0;
        err_d   = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
        vidx_d  = '0;
        vsum_d  = '0;
`endif
      end
      LOAD: if (mem_we_o) begin
        count_d = count_q + 9'd1;
        sum_d   = sum_q + in_data_i;
        stall_d = '0;
`ifdef MEM_LOADER_VERIFY_EN
        if (count_d == len_q) state_d = VERIFY;
`else
        if (count_d == len_q) state_d = DONE;
`endif
      end else begin
        stall_d = stall_q + 8'd1;
        if (stall_d == LIM) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      VERIFY: begin
        vidx_d = vidx_q + 9'd1;
        vsum_d = vsum_q + mem_dout_i;
        if (vidx_d == len_q) begin
          state_d = DONE;
          err_d   = vsum_d != sum_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
`ifdef MEM_LOADER_VERIFY_EN
  assign busy_o = state_q == LOAD || state_q == VERIFY;
`else
  assign busy_o = state_q == LOAD;
`endif
  assign done_o     = state_q == DONE;
  assign error_o    = err_q;
  assign count_o    = count_q;
  assign checksum_o = sum_q;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed table vectors, reset abort, and randomized gapped streams against a transfer-level model.
module tb_mem_loader;
  localparam int LIM = 4;
`ifdef MEM_LOADER_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_ready, mem_we, busy, done, error;
  logic [7:0] base, length, in_data, mem_addr, mem_din, mem_dout, checksum;
  logic [8:0] count;
  logic [7:0] mem [256];
  logic       corrupt_en;
  logic [7:0] corrupt_addr;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         busy_cyc = 0;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] dq[$];
  int         gq[$];

  mem_loader #(.STALL_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .length_i(length),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_we_o(mem_we), .mem_dout_i(mem_dout), .busy_o(busy),
    .done_o(done), .error_o(error), .count_o(count), .checksum_o(checksum)
  );

  always #5 clk = ~clk;
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= (corrupt_en && mem_addr == corrupt_addr) ? mem_din ^ 8'hFF : mem_din;
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
    end
    if (busy) busy_cyc++;
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Drives one transfer from dq/gq (gq[i] idle cycles precede byte i) and checks it against the model.
  task automatic run(input logic [7:0] b, input logic [7:0] l, input bit noise,
                     output int a_cnt, output int a_sum, output int a_err);
    int eff, n, sum, ab, hit, ecyc, w0, c0, bad_w, bad_m, idle;
    logic [7:0] ad;
    eff = (l == 0) ? 256 : int'(l);
    n = 0; sum = 0; ab = 0; hit = 0; ecyc = 0; bad_w = 0; bad_m = 0;
    for (int i = 0; i < eff; i++) begin
      if (gq[i] >= LIM) begin
        ab = 1;
        ecyc += LIM;
        break;
      end
      ecyc += gq[i] + 1;
      sum = (sum + int'(dq[i])) % 256;
      if (corrupt_en && 8'(int'(b) + i) == corrupt_addr) hit = 1;
      n++;
    end
    if (!ab && VEN) ecyc += eff;
    w0 = wa.size();
    c0 = busy_cyc;
    @(negedge clk);
    start = 1'b1; base = b; length = l; in_valid = 1'b0;
    for (int i = 0; i < eff; i++) begin
      idle = (gq[i] >= LIM) ? LIM : gq[i];
      for (int g = 0; g < idle; g++) begin
        @(negedge clk);
        start = noise && ($urandom_range(0, 2) == 0);
        base = 8'($urandom); length = 8'($urandom);
        in_valid = 1'b0; in_data = 8'($urandom);
      end
      if (gq[i] >= LIM) break;
      @(negedge clk);
      start = noise && ($urandom_range(0, 2) == 0);
      base = 8'($urandom); length = 8'($urandom);
      in_valid = 1'b1; in_data = dq[i];
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 700 && !done; t++) @(negedge clk);
    chk("done_reached", int'(done), 1);
    chk("busy_after", int'(busy), 0);
    chk("ready_after", int'(in_ready), 0);
    chk("count", int'(count), n);
    chk("checksum", int'(checksum), sum);
    chk("error", int'(error), (ab || (VEN && hit)) ? 1 : 0);
    chk("busy_cycles", busy_cyc - c0, ecyc);
    chk("n_writes", wa.size() - w0, n);
    for (int i = 0; i < n && w0 + i < wa.size(); i++) begin
      ad = 8'(int'(b) + i);
      if (wa[w0 + i] !== ad || wd[w0 + i] !== dq[i]) bad_w++;
      if (mem[ad] !== (dq[i] ^ ((corrupt_en && ad == corrupt_addr) ? 8'hFF : 8'h00))) bad_m++;
    end
    chk("write_log", bad_w, 0);
    chk("mem_content", bad_m, 0);
    a_cnt = int'(count); a_sum = int'(checksum); a_err = int'(error);
  endtask

  typedef struct {
    logic [7:0] b, l, first, step;
    int         nsend, cnt, sum, err;
  } vec_t;

  task automatic fill(input int eff, input logic [7:0] first, input logic [7:0] step, input int nsend);
    dq.delete(); gq.delete();
    for (int i = 0; i < eff; i++) begin
      dq.push_back(8'(int'(first) + i * int'(step)));
      gq.push_back(i == nsend ? LIM : 0);
    end
  endtask

  initial begin
    vec_t vec[5];
    int ac, as, ae, eff, l, ab_at;
    vec[0] = '{8'h08, 8'd20, 8'h01, 8'h01, 20, 20, 8'hD2, 0};
    vec[1] = '{8'hFE, 8'd4, 8'hAA, 8'h11, 4, 4, 8'h0E, 0};
    vec[2] = '{8'h00, 8'd0, 8'h01, 8'h00, 256, 256, 8'h00, 0};
    vec[3] = '{8'h40, 8'd10, 8'h01, 8'h01, 3, 3, 8'h06, 1};
    vec[4] = '{8'h30, 8'd10, 8'h01, 8'h01, 10, 10, 8'h37, 0};
    rst_n = 1'b0; start = 1'b0; base = '0; length = '0; in_data = '0; in_valid = 1'b0;
    corrupt_en = 1'b0; corrupt_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_addr", int'(mem_addr), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eff = (vec[k].l == 0) ? 256 : int'(vec[k].l);
      fill(eff, vec[k].first, vec[k].step, vec[k].nsend);
      run(vec[k].b, vec[k].l, 1'b0, ac, as, ae);
      chk($sformatf("vec%0d_cnt", k), ac, vec[k].cnt);
      chk($sformatf("vec%0d_sum", k), as, vec[k].sum);
      chk($sformatf("vec%0d_err", k), ae, vec[k].err);
    end
    // Asynchronous reset while the 5th byte of a 10-byte transfer is on the bus.
    @(negedge clk);
    start = 1'b1; base = 8'h30; length = 8'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 8'(i + 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(in_ready), 0);
    chk("arst_we", int'(mem_we), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_sum", int'(checksum), 0);
    chk("arst_addr", int'(mem_addr), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_kept", int'(mem[8'h33]), 4);
    @(posedge clk);
    #2 in_valid = 1'b0; rst_n = 1'b1;
    fill(10, vec[4].first, vec[4].step, vec[4].nsend);
    run(vec[4].b, vec[4].l, 1'b0, ac, as, ae);
    chk("vec4_cnt", ac, vec[4].cnt);
    chk("vec4_sum", as, vec[4].sum);
    chk("vec4_err", ae, vec[4].err);
`ifdef MEM_LOADER_VERIFY_EN
    corrupt_en = 1'b1; corrupt_addr = 8'h52;
    fill(8, 8'h10, 8'h03, 8);
    run(8'h50, 8'd8, 1'b0, ac, as, ae);
    chk("corrupt_err", ae, 1);
    corrupt_en = 1'b0;
    run(8'h50, 8'd8, 1'b0, ac, as, ae);
    chk("clean_err", ae, 0);
`endif
    for (int r = 0; r < 25; r++) begin
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      eff = (l == 0) ? 256 : l;
      ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, eff - 1) : -1;
      dq.delete(); gq.delete();
      for (int i = 0; i < eff; i++) begin
        dq.push_back(8'($urandom));
        gq.push_back(i == ab_at ? $urandom_range(LIM, LIM + 2) : $urandom_range(0, LIM - 1));
      end
      run(8'($urandom), 8'(l), 1'b1, ac, as, ae);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: STALL_LIMIT, default 255; consecutive in_valid-low cycles in LOAD that abort the transfer (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin transfer; sampled only in IDLE or DONE.
REQ-005 base_addr  input  8  first memory address, captured on accepted start.
REQ-006 length  input  8  byte count, captured on accepted start; 0 means 256.
REQ-007 in_data  input  8  byte stream data.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_addr  output  8  address to downstream memory.
REQ-011 mem_din  output  8  write data to downstream memory.
REQ-012 mem_we  output  1  write enable to downstream memory.
REQ-013 mem_dout  input  8  combinational read data from memory at mem_addr.
REQ-014 busy  output  1  high in LOAD or VERIFY.
REQ-015 done  output  1  high in DONE.
REQ-016 error  output  1  stall abort or verify mismatch; valid while done=1.
REQ-017 count  output  9  bytes written in current/last transfer (0..256).
REQ-018 checksum  output  8  mod-256 sum of bytes written in current/last transfer.

Function
REQ-019 States IDLE, LOAD, VERIFY, DONE; IDLE/DONE with start=1 -> LOAD, capturing base_addr, length (0 -> 256), clearing count, checksum, error, stall counter.
REQ-020 start while busy SHALL be ignored.
REQ-021 In LOAD, in_ready=1; transfer occurs when in_valid&&in_ready at a rising edge.
REQ-022 mem_we=in_valid&&in_ready, mem_din=in_data, mem_addr=(base+count) mod 256, all combinational, so the write completes on the accepting edge (zero latency).
REQ-023 Each transfer increments count by 1 and adds in_data to checksum mod 256.
REQ-024 Address SHALL wrap 255 -> 0 without error.
REQ-025 Transfer that makes count equal length -> VERIFY (macro defined) or DONE (macro undefined) on the same edge.
REQ-026 Stall counter increments each LOAD cycle with in_valid=0, clears on each transfer; reaching STALL_LIMIT -> DONE with error=1, no further writes.
REQ-027 Outside LOAD, in_ready=0 and mem_we=0; mem_din=0.
REQ-028 DONE held until next start; count and checksum held valid.

Reset
REQ-029 rst=0 SHALL immediately force IDLE; busy, done, error, in_ready, mem_we=0; count=0; checksum=0; mem_addr=0; captured base/length=0.
REQ-030 Reset mid-LOAD or mid-VERIFY aborts without completing; bytes already written remain in memory.

Configuration
REQ-031 Macro MEM_LOADER_VERIFY_EN defined: VERIFY state compiled in; reads one byte per cycle at mem_addr=(base+vidx) mod 256, vidx 0..length-1, mem_we=0, summing mem_dout mod 256; after length cycles -> DONE, error=1 if sum != checksum.
REQ-032 Macro undefined: no VERIFY state, no readback logic; LOAD completion goes straight to DONE with error=0.

Verification
REQ-033 base=0x08, length=20, bytes 1..20 continuous valid -> memory[8..27]=1..20, count=20, checksum=0xD2, done=1, error=0.
REQ-034 base=0xFE, length=4, bytes AA,BB,CC,DD -> writes at FE,FF,00,01; checksum=0x0E; error=0.
REQ-035 length=0, 256 bytes all 0x01 -> count=256, checksum=0x00, done=1.
REQ-036 STALL_LIMIT=4, length=10, in_valid dropped after 3 bytes -> DONE after 4 idle cycles, error=1, count=3, no further mem_we.
REQ-037 rst pulsed low during 5th byte of length=10 -> all outputs to reset values asynchronously, state IDLE; new start runs normally.
REQ-038 MEM_LOADER_VERIFY_EN defined, memory model corrupts one written byte before VERIFY -> error=1 at done; uncorrupted run -> error=0, busy length cycles longer than macro-undefined build.
